// File: rtl/mem_port_arbiter.sv
// Shares the single off-chip line-memory port between icache (port 0) and dcache (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (port 1 wins).
module mem_port_arbiter #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t            state, state_next;
  logic              owner, owner_next;
  logic              winner;
  logic [15:0]       timer, timer_next, timer_inc;
  logic              mem_enable_next, mem_write_next, err_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_data_next;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr, ptr_next;

  always_comb begin
    if (p0_enable_i && p1_enable_i) winner = ptr;
    else                            winner = p1_enable_i;
  end
`else
  assign winner = p1_enable_i;
`endif

  // timer counts completed GRANT cycles; the cycle that brings it to TIMEOUT is the last one
  assign timer_inc = timer + 16'd1;

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    timer_next      = timer;
    mem_enable_next = mem_enable_o;
    mem_write_next  = mem_write_o;
    mem_addr_next   = mem_addr_o;
    mem_data_next   = mem_data_o;
    err_next        = err_o;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_next        = ptr;
`endif
    case (state)
      IDLE: begin
        if (p0_enable_i || p1_enable_i) begin
          state_next      = GRANT;
          owner_next      = winner;
          timer_next      = '0;
          mem_enable_next = 1'b1;
          mem_write_next  = winner ? p1_write_i : p0_write_i;
          mem_addr_next   = winner ? p1_addr_i  : p0_addr_i;
          mem_data_next   = winner ? p1_data_i  : p0_data_i;
        end
      end
      GRANT: begin
        timer_next = timer_inc;
        if (mem_ack_i) begin
          state_next      = RELEASE;
          mem_enable_next = 1'b0;
          mem_write_next  = 1'b0;
        end else if (timer_inc == TIMEOUT_CNT) begin
          state_next      = RELEASE;
          mem_enable_next = 1'b0;
          mem_write_next  = 1'b0;
          err_next        = 1'b1;
        end
      end
      RELEASE: begin
        state_next = IDLE;
        timer_next = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_next   = ~owner;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      owner        <= 1'b0;
      timer        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      err_o        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr          <= 1'b1;
`endif
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      timer        <= timer_next;
      mem_enable_o <= mem_enable_next;
      mem_write_o  <= mem_write_next;
      mem_addr_o   <= mem_addr_next;
      mem_data_o   <= mem_data_next;
      err_o        <= err_next;
`ifdef ARB_ROUND_ROBIN_EN
      ptr          <= ptr_next;
`endif
    end
  end

  // completion is routed only to the current owner and only while a grant is live
  assign p0_ack_o  = mem_ack_i && (state == GRANT) && !owner;
  assign p1_ack_o  = mem_ack_i && (state == GRANT) && owner;
  assign p0_data_o = ((state == GRANT) && !owner) ? mem_data_i : '0;
  assign p1_data_o = ((state == GRANT) && owner)  ? mem_data_i : '0;

endmodule
